// File: rtl/mem_access_sequencer_if.sv
// Handshake and bus signals between the control unit, the sequencer and the memory bus.
// The master side (control unit plus memory model) drives the requests; the sequencer is the slave.
interface mem_access_sequencer_if #(
    parameter int unsigned WORD = 16
);
    logic            start_i;
    logic            isStore_i;
    logic            isByte_i;
    logic [WORD-1:0] base_i;
    logic [WORD-1:0] memOffs_i;
    logic [WORD-1:0] storeData_i;
    logic            busy_o;
    logic            done_o;
    logic            fault_o;
    logic [1:0]      faultCode_o;
    logic [WORD-1:0] loadData_o;
    logic [WORD-1:0] memAddr_o;
    logic [WORD-1:0] memWrData_o;
    logic            memWr_o;
    logic            memByte_o;
    logic            memReq_o;
    logic            memAck_i;
    logic [WORD-1:0] memRdData_i;

    modport master (
        output start_i, isStore_i, isByte_i, base_i, memOffs_i, storeData_i,
        output memAck_i, memRdData_i,
        input  busy_o, done_o, fault_o, faultCode_o, loadData_o,
        input  memAddr_o, memWrData_o, memWr_o, memByte_o, memReq_o
    );

    modport slave (
        input  start_i, isStore_i, isByte_i, base_i, memOffs_i, storeData_i,
        input  memAck_i, memRdData_i,
        output busy_o, done_o, fault_o, faultCode_o, loadData_o,
        output memAddr_o, memWrData_o, memWr_o, memByte_o, memReq_o
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer: forms base+offset, runs the req/ack bus handshake with a timeout,
// and returns aligned load data or a fault code to the control unit.
module mem_access_sequencer #(
    parameter int unsigned WORD    = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                  clk_i,
    input logic                  rst_i,
    mem_access_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAddr, StReq, StDone} state_e;

    state_e          state_q;
    logic            store_q;
    logic            byte_q;
    logic [WORD-1:0] base_q;
    logic [WORD-1:0] offs_q;
    logic [WORD-1:0] sdata_q;
    logic [15:0]     cnt_q;

    logic            busy_q;
    logic            done_q;
    logic            fault_q;
    logic [1:0]      code_q;
    logic [WORD-1:0] ld_q;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] wdata_q;
    logic            wr_q;
    logic            mbyte_q;
    logic            req_q;

    logic [WORD-1:0] ea;

    // Carry out of the address add is discarded.
    always_comb begin
        ea = base_q + offs_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            store_q <= 1'b0;
            byte_q  <= 1'b0;
            base_q  <= '0;
            offs_q  <= '0;
            sdata_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
            ld_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            mbyte_q <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        store_q <= bus.isStore_i;
                        byte_q  <= bus.isByte_i;
                        base_q  <= bus.base_i;
                        offs_q  <= bus.memOffs_i;
                        sdata_q <= bus.storeData_i;
                        busy_q  <= 1'b1;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    addr_q  <= ea;
                    wdata_q <= byte_q ? {(WORD/8){sdata_q[7:0]}} : sdata_q;
                    if (!byte_q && ea[0]) begin
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                        code_q  <= 2'b01;
                        state_q <= StDone;
                    end else begin
                        req_q   <= 1'b1;
                        wr_q    <= store_q;
                        mbyte_q <= byte_q;
                        cnt_q   <= '0;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    // Ack wins over a coincident timeout.
                    if (bus.memAck_i) begin
                        if (!store_q) begin
                            if (!byte_q) begin
                                ld_q <= bus.memRdData_i;
                            end else if (addr_q[0]) begin
                                ld_q <= {{(WORD-8){1'b0}}, bus.memRdData_i[15:8]};
                            end else begin
                                ld_q <= {{(WORD-8){1'b0}}, bus.memRdData_i[7:0]};
                            end
                        end
                        req_q   <= 1'b0;
                        wr_q    <= 1'b0;
                        mbyte_q <= 1'b0;
                        done_q  <= 1'b1;
                        fault_q <= 1'b0;
                        code_q  <= 2'b00;
                        state_q <= StDone;
                    end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        wr_q    <= 1'b0;
                        mbyte_q <= 1'b0;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                        code_q  <= 2'b10;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    code_q  <= 2'b00;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.fault_o     = fault_q;
    assign bus.faultCode_o = code_q;
    assign bus.loadData_o  = ld_q;
    assign bus.memAddr_o   = addr_q;
    assign bus.memWrData_o = wdata_q;
    assign bus.memWr_o     = wr_q;
    assign bus.memByte_o   = mbyte_q;
    assign bus.memReq_o    = req_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed scenarios plus randomized accesses
// compared against a transaction-level model of address, latency, fault and load data.
module tb_mem_access_sequencer;
    localparam int unsigned WORD = 16;
    localparam int unsigned TMO  = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [15:0] exp_ld;

    always #5 clk = ~clk;

    mem_access_sequencer_if #(.WORD(WORD)) bus ();

    mem_access_sequencer #(.WORD(WORD), .TIMEOUT(TMO)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // One complete access; w = REQ wait cycles before ack (w >= TMO means never acked).
    task automatic run_access(input string name, input bit st, input bit by,
                              input logic [15:0] base, input logic [15:0] offs,
                              input logic [15:0] sd, input logic [15:0] rd, input int w);
        logic [15:0] ea, wd;
        int code, lat, nreq, k, reqs;
        bit fin;
        ea = base + offs;
        wd = by ? {sd[7:0], sd[7:0]} : sd;
        if (!by && ea[0]) begin
            code = 1; nreq = 0; lat = 2;
        end else if (w >= int'(TMO)) begin
            code = 2; nreq = TMO; lat = 2 + TMO;
        end else begin
            code = 0; nreq = w + 1; lat = 3 + w;
        end
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0)
            $display("FAIL %s idle: busy=%b done=%b want 0 0", name, bus.busy_o, bus.done_o);
        bus.start_i = 1'b1; bus.isStore_i = st; bus.isByte_i = by;
        bus.base_i = base; bus.memOffs_i = offs; bus.storeData_i = sd;
        bus.memRdData_i = rd; bus.memAck_i = 1'b0;
        @(posedge clk);
        k = 0; reqs = 0; fin = 1'b0;
        while (!fin && k < 40) begin
            @(negedge clk);
            k++;
            bus.memAck_i = 1'b0;
            if (k == 1) begin
                bus.start_i = 1'b0;
                bus.isStore_i = 1'($urandom); bus.isByte_i = 1'($urandom);
                bus.base_i = 16'($urandom); bus.memOffs_i = 16'($urandom);
                bus.storeData_i = 16'($urandom);
            end
            if (bus.memReq_o === 1'b1) begin
                reqs++;
                checks++;
                if (bus.memAddr_o !== ea || bus.memWr_o !== st || bus.memByte_o !== by ||
                    bus.memWrData_o !== wd) begin
                    errors++;
                    $display("FAIL %s bus: addr=%h wr=%b byte=%b wdata=%h want %h %b %b %h",
                             name, bus.memAddr_o, bus.memWr_o, bus.memByte_o, bus.memWrData_o,
                             ea, st, by, wd);
                end
                if (reqs == w + 1) bus.memAck_i = 1'b1;
            end
            if (bus.done_o === 1'b1) fin = 1'b1;
        end
        if (code == 0 && !st)
            exp_ld = by ? (ea[0] ? {8'h00, rd[15:8]} : {8'h00, rd[7:0]}) : rd;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL %s done: no done_o within 40 cycles, want at cycle %0d", name, lat);
        end else begin
            checks += 5;
            if (k != lat) begin
                errors++;
                $display("FAIL %s latency: got %0d want %0d", name, k, lat);
            end
            if (bus.fault_o !== (code != 0) || bus.faultCode_o !== 2'(code)) begin
                errors++;
                $display("FAIL %s fault: got %b/%b want %b/%0d", name, bus.fault_o,
                         bus.faultCode_o, code != 0, code);
            end
            if (reqs != nreq) begin
                errors++;
                $display("FAIL %s req_cycles: got %0d want %0d", name, reqs, nreq);
            end
            if (bus.memAddr_o !== ea) begin
                errors++;
                $display("FAIL %s addr: got %h want %h", name, bus.memAddr_o, ea);
            end
            if (bus.loadData_o !== exp_ld) begin
                errors++;
                $display("FAIL %s load_data: got %h want %h", name, bus.loadData_o, exp_ld);
            end
        end
        bus.memAck_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.isStore_i = 1'b0; bus.isByte_i = 1'b0;
        bus.base_i = '0; bus.memOffs_i = '0; bus.storeData_i = '0;
        bus.memAck_i = 1'b1; bus.memRdData_i = 16'hFFFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy_o, bus.done_o, bus.fault_o, bus.memReq_o, bus.memWr_o, bus.memByte_o,
             bus.faultCode_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000", {bus.busy_o, bus.done_o,
                     bus.fault_o, bus.memReq_o, bus.memWr_o, bus.memByte_o, bus.faultCode_o});
        end
        checks++;
        if (bus.loadData_o !== 16'h0 || bus.memAddr_o !== 16'h0 || bus.memWrData_o !== 16'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h want 0 0 0", bus.loadData_o,
                     bus.memAddr_o, bus.memWrData_o);
        end
        rst = 1'b0;
        exp_ld = 16'h0;
        // Ack while idle must be ignored.
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.memReq_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: busy=%b req=%b want 0 0", bus.busy_o, bus.memReq_o);
        end
        bus.memAck_i = 1'b0;
    endtask

    task automatic test_directed();
        run_access("word_load", 1'b0, 1'b0, 16'h1000, 16'hFFFE, 16'h0000, 16'hBEEF, 0);
        run_access("byte_store", 1'b1, 1'b1, 16'h2001, 16'h0000, 16'h12A5, 16'h0000, 2);
        run_access("byte_load_odd", 1'b0, 1'b1, 16'h3000, 16'h0003, 16'h0000, 16'h7F80, 0);
        run_access("byte_load_even", 1'b0, 1'b1, 16'h3000, 16'h0002, 16'h0000, 16'h7F80, 1);
        run_access("misaligned_load", 1'b0, 1'b0, 16'h0004, 16'h0001, 16'h0000, 16'h1234, 0);
        run_access("misaligned_store", 1'b1, 1'b0, 16'hFFFF, 16'h0002, 16'h5A5A, 16'h0000, 0);
        run_access("timeout", 1'b0, 1'b0, 16'h0100, 16'h0010, 16'h0000, 16'hCAFE, 100);
        run_access("ack_at_limit", 1'b0, 1'b0, 16'h0100, 16'h0010, 16'h0000, 16'hCAFE, 3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_access("random", 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                       16'($urandom), 16'($urandom), int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_async_reset();
        int n;
        @(negedge clk);
        bus.start_i = 1'b1; bus.isStore_i = 1'b0; bus.isByte_i = 1'b0;
        bus.base_i = 16'h0010; bus.memOffs_i = 16'h0000; bus.memAck_i = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b0;
        n = 0;
        while (bus.memReq_o !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.memReq_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_setup: req=%b want 1", bus.memReq_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.memReq_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_drop: req=%b busy=%b want 0 0", bus.memReq_o, bus.busy_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.done_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_done: done=%b want 0", bus.done_o);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_ld = 16'h0;
    endtask

    task automatic test_start_in_done();
        int n;
        bit fin;
        @(negedge clk);
        bus.start_i = 1'b1; bus.isStore_i = 1'b0; bus.isByte_i = 1'b1;
        bus.base_i = 16'h3001; bus.memOffs_i = 16'h0000; bus.memRdData_i = 16'h5566;
        @(negedge clk);
        bus.start_i = 1'b0;
        n = 0; fin = 1'b0;
        while (!fin && n < 20) begin
            @(negedge clk);
            n++;
            bus.memAck_i = (bus.memReq_o === 1'b1);
            fin = (bus.done_o === 1'b1);
        end
        exp_ld = 16'h0055;
        // Raise start in the DONE cycle: must be ignored.
        bus.start_i = 1'b1; bus.isStore_i = 1'b1; bus.isByte_i = 1'b0;
        bus.base_i = 16'h4000; bus.memOffs_i = 16'h0002; bus.storeData_i = 16'h9999;
        bus.memAck_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy_o !== 1'b0 || bus.loadData_o !== exp_ld) begin
            errors++;
            $display("FAIL start_in_done: busy=%b ld=%h want 0 %h", bus.busy_o,
                     bus.loadData_o, exp_ld);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL start_in_idle: busy=%b want 1", bus.busy_o);
        end
        n = 0; fin = 1'b0;
        while (!fin && n < 20) begin
            @(negedge clk);
            n++;
            bus.memAck_i = (bus.memReq_o === 1'b1);
            fin = (bus.done_o === 1'b1);
        end
        bus.memAck_i = 1'b0;
        checks++;
        if (!fin || bus.fault_o !== 1'b0 || bus.memAddr_o !== 16'h4002 ||
            bus.loadData_o !== exp_ld) begin
            errors++;
            $display("FAIL store_after_done: fin=%b fault=%b addr=%h ld=%h want 1 0 4002 %h",
                     fin, bus.fault_o, bus.memAddr_o, bus.loadData_o, exp_ld);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_async_reset();
        test_start_in_done();
        run_access("after_reset_load", 1'b0, 1'b0, 16'h0FFF, 16'h0001, 16'h0, 16'h1357, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
